// File: rtl/mem_bus_responder_pkg.sv
// Shared constants for the data-memory bus responder: access size codes,
// FSM state encodings and the default decode base.
package mem_bus_responder_pkg;

  localparam logic [1:0] MASK_WORD = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_BYTE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef struct packed {
    logic        we;
    logic [1:0]  mask;
    logic        sext;
    logic [31:0] wdata;
  } req_t;

  // The reserved size code 2'b11 behaves as a word.
  function automatic logic misaligned(input logic [1:0] mask, input logic [1:0] lsb);
    case (mask)
      MASK_HALF: return lsb[0];
      MASK_BYTE: return 1'b0;
      default:   return lsb != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_byte_array.sv
// Word-organised storage with per-byte write enables and a registered
// aligned-word read. Contents are deliberately not reset.
module mem_bus_byte_array #(
  parameter  int unsigned DEPTH_BYTES = 2048,
  localparam int unsigned NUM_WORDS   = DEPTH_BYTES / 4,
  localparam int unsigned WA_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic            clk_i,
  input  logic            wr_en_i,
  input  logic [3:0]      be_i,
  input  logic            rd_en_i,
  input  logic [WA_W-1:0] word_addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [NUM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[word_addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (rd_en_i) rdata_q <= mem_q[word_addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Handshaked, multi-cycle, byte-addressed data-memory responder with
// programmable wait states and alignment/range error reporting.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 2048,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  mask_i,
  input  logic        signed_ext_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned OFF_W     = $clog2(DEPTH_BYTES);
  localparam int unsigned NUM_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned WA_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             err_q, err_d;

  logic [31:0] off_full;
  logic        bad_req;
  logic        commit;

  // Unsigned subtract: addresses below the base underflow and fail the range test.
  assign off_full = addr_i - BASE_ADDR;
  assign bad_req  = (off_full >= 32'(DEPTH_BYTES)) || misaligned(mask_i, addr_i[1:0]);
  assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    off_d   = off_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          req_d.we    = we_i;
          req_d.mask  = mask_i;
          req_d.sext  = signed_ext_i;
          req_d.wdata = wdata_i;
          off_d       = off_full[OFF_W-1:0];
          err_d       = bad_req;
          cnt_d       = WAIT_INIT;
          state_d     = bad_req ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  logic [1:0]      lane;
  logic [3:0]      wr_be;
  logic [31:0]     wr_word;
  logic [31:0]     arr_rdata;
  logic [WA_W-1:0] word_addr;

  assign lane      = off_q[1:0];
  assign word_addr = WA_W'(off_q >> 2);

  // Narrow writes replicate the data across lanes; the enables pick the lane.
  always_comb begin
    wr_be   = 4'b1111;
    wr_word = req_q.wdata;
    case (req_q.mask)
      MASK_HALF: begin
        wr_be   = off_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_q.wdata[15:0]}};
      end
      MASK_BYTE: begin
        wr_be   = 4'b0001 << lane;
        wr_word = {4{req_q.wdata[7:0]}};
      end
      default: ;
    endcase
  end

  mem_bus_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk_i      (clk_i),
    .wr_en_i    (commit && req_q.we),
    .be_i       (wr_be),
    .rd_en_i    (commit && !req_q.we),
    .word_addr_i(word_addr),
    .wdata_i    (wr_word),
    .rdata_o    (arr_rdata)
  );

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    rd_byte = arr_rdata[{lane, 3'b000} +: 8];
    rd_half = off_q[1] ? arr_rdata[31:16] : arr_rdata[15:0];
    case (req_q.mask)
      MASK_HALF: rd_ext = {{16{req_q.sext & rd_half[15]}}, rd_half};
      MASK_BYTE: rd_ext = {{24{req_q.sext & rd_byte[7]}}, rd_byte};
      default:   rd_ext = arr_rdata;
    endcase
  end

  assign ready_o = (state_q == ST_RESP);
  assign err_o   = ready_o & err_q;
  assign rdata_o = (ready_o && !err_q && !req_q.we) ? rd_ext : 32'h0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed transactions checked against literals,
// plus a per-cycle comparison against a transaction-level memory model.
module tb_mem_bus_responder;
  import mem_bus_responder_pkg::*;

  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req0 = 1'b0, we = 1'b0, sext = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  mask = '0;
  logic        ready, err, ready0, err0;
  logic [31:0] rdata, rdata0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .reset_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .mask_i(mask),
    .signed_ext_i(sext), .wdata_i(wdata), .ready_o(ready), .rdata_o(rdata), .err_o(err));

  mem_bus_responder #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(rst), .req_i(req0), .we_i(we), .addr_i(addr), .mask_i(mask),
    .signed_ext_i(sext), .wdata_i(wdata), .ready_o(ready0), .rdata_o(rdata0), .err_o(err0));

  // Transaction-level model of the WS=2 instance: one outstanding access at a time.
  logic [7:0]  mmem [int];
  bit          pend = 0;
  int          resp_cyc = 0, free_from = 0, p_off = 0;
  bit          p_we = 0, p_err = 0;
  logic [31:0] p_rdata = '0, p_wdata = '0;
  logic [1:0]  p_mask = '0;

  function automatic logic [31:0] model_read(input int o, input logic [1:0] m, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = mmem[o];
    if (m == MASK_BYTE) return {{24{sx & b[7]}}, b};
    h = {mmem[o+1], mmem[o]};
    if (m == MASK_HALF) return {{16{sx & h[15]}}, h};
    return {mmem[o+3], mmem[o+2], mmem[o+1], mmem[o]};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] o;
    bit          e;
    if (rst) begin
      pend      = 0;
      free_from = 0;
    end else begin
      if (pend && p_we && !p_err && cyc == resp_cyc - 1) begin
        mmem[p_off] = p_wdata[7:0];
        if (p_mask != MASK_BYTE) mmem[p_off+1] = p_wdata[15:8];
        if (p_mask != MASK_BYTE && p_mask != MASK_HALF) begin
          mmem[p_off+2] = p_wdata[23:16];
          mmem[p_off+3] = p_wdata[31:24];
        end
      end
      if (req && cyc >= free_from) begin
        o = addr - BASE;
        e = (o >= 32'(DEPTH)) ||
            (mask == MASK_HALF && addr[0]) ||
            (mask != MASK_HALF && mask != MASK_BYTE && addr[1:0] != 2'b00);
        pend      = 1;
        p_err     = e;
        p_we      = we;
        p_off     = int'(o);
        p_mask    = mask;
        p_wdata   = wdata;
        resp_cyc  = e ? cyc + 1 : cyc + WS + 2;
        free_from = resp_cyc + 1;
        p_rdata   = (e || we) ? 32'h0 : model_read(int'(o), mask, sext);
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic        er, ee;
    logic [31:0] ed;
    er = pend && (cyc == resp_cyc);
    ee = er && p_err;
    ed = er ? p_rdata : 32'h0;
    n_tests++;
    if (ready !== er || err !== ee || rdata !== ed) begin
      n_fail++;
      $display("FAIL model_cmp cycle %0d: ready=%b err=%b rdata=%h, required ready=%b err=%b rdata=%h",
               cyc, ready, err, rdata, er, ee, ed);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic txn(input bit on0, input bit w, input logic [31:0] a, input logic [1:0] m,
                     input bit sx, input logic [31:0] wd, input int exp_lat, input bit exp_err,
                     input logic [31:0] exp_rd, input string nm);
    int c0;
    bit got;
    @(posedge clk); #1;
    we = w; addr = a; mask = m; sext = sx; wdata = wd;
    if (on0) req0 = 1'b1; else req = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    req = 1'b0; req0 = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((on0 ? ready0 : ready) === 1'b1) got = 1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no ready within 30 cycles, required latency %0d", nm, exp_lat);
    end else begin
      chk({nm, "_lat"}, 32'(cyc - c0), 32'(exp_lat));
      chk({nm, "_err"}, {31'b0, on0 ? err0 : err}, {31'b0, exp_err});
      chk({nm, "_rdata"}, on0 ? rdata0 : rdata, exp_rd);
    end
  endtask

  initial begin
    int c0, pulses, first, last, gap;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    #2 rst = 1'b0;

    txn(0, 1, BASE + 32'h10, MASK_WORD, 0, 32'hDEAD_BEEF, 4, 0, 32'h0, "wr_word");
    txn(0, 0, BASE + 32'h10, MASK_WORD, 0, 32'h0, 4, 0, 32'hDEAD_BEEF, "rd_word");
    txn(0, 0, BASE + 32'h13, MASK_BYTE, 1, 32'h0, 4, 0, 32'hFFFF_FFDE, "rd_byte_s");
    txn(0, 0, BASE + 32'h13, MASK_BYTE, 0, 32'h0, 4, 0, 32'h0000_00DE, "rd_byte_u");
    txn(0, 0, BASE + 32'h10, MASK_HALF, 1, 32'h0, 4, 0, 32'hFFFF_BEEF, "rd_half_s");
    txn(0, 1, BASE + 32'h12, MASK_HALF, 0, 32'h0000_1234, 4, 0, 32'h0, "wr_half");
    txn(0, 0, BASE + 32'h10, MASK_WORD, 1, 32'h0, 4, 0, 32'h1234_BEEF, "rd_after_half");
    txn(0, 0, BASE + 32'h10, 2'b11, 0, 32'h0, 4, 0, 32'h1234_BEEF, "rd_mask11");
    txn(0, 1, BASE + 32'h7FC, MASK_WORD, 0, 32'hA5A5_0F0F, 4, 0, 32'h0, "wr_last_word");
    txn(0, 0, BASE + 32'h2, MASK_WORD, 0, 32'h0, 1, 1, 32'h0, "err_misalign_w");
    txn(0, 0, BASE + 32'h11, MASK_HALF, 0, 32'h0, 1, 1, 32'h0, "err_misalign_h");
    txn(0, 1, BASE + 32'h800, MASK_WORD, 0, 32'h9999_9999, 1, 1, 32'h0, "err_range");
    txn(0, 0, BASE + 32'h7FC, MASK_WORD, 0, 32'h0, 4, 0, 32'hA5A5_0F0F, "rd_unchanged");
    txn(0, 0, 32'h0000_0000, MASK_WORD, 0, 32'h0, 1, 1, 32'h0, "err_below_base");
    txn(0, 1, BASE + 32'h7FF, MASK_BYTE, 0, 32'h0000_0077, 4, 0, 32'h0, "wr_last_byte");
    txn(0, 0, BASE + 32'h7FC, MASK_WORD, 0, 32'h0, 4, 0, 32'h77A5_0F0F, "rd_last_word");

    // req held high for 16 sampled cycles: accepts at +0,+5,+10,+15.
    @(posedge clk); #1;
    we = 0; addr = BASE + 32'h10; mask = MASK_WORD; sext = 0; req = 1'b1;
    c0 = cyc; pulses = 0; first = -1; last = -1; gap = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc - c0;
        gap  = (cyc - c0) - last;
        last = cyc - c0;
      end
      @(posedge clk); #1;
      if (cyc - c0 == 16) req = 1'b0;
    end
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_first", 32'(first), 32'd4);
    chk("b2b_gap", 32'(gap), 32'd5);
    chk("b2b_last", 32'(last), 32'd19);

    // Extra req pulse while waiting must be dropped.
    @(posedge clk); #1;
    req = 1'b1; c0 = cyc; pulses = 0; first = -1;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc - c0;
      end
    end
    chk("wait_req_pulses", 32'(pulses), 32'd1);
    chk("wait_req_first", 32'(first), 32'd4);

    // Reset during the first wait cycle must abort the write.
    txn(0, 1, BASE + 32'h20, MASK_WORD, 0, 32'hDEAD_BEEF, 4, 0, 32'h0, "wr_abort_setup");
    @(posedge clk); #1;
    we = 1; addr = BASE + 32'h20; mask = MASK_WORD; wdata = 32'h5555_5555; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    #1;
    chk("abort_ready", {31'b0, ready}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    @(negedge clk); #2 rst = 1'b0;
    txn(0, 0, BASE + 32'h20, MASK_WORD, 0, 32'h0, 4, 0, 32'hDEAD_BEEF, "rd_after_abort");

    txn(1, 1, BASE + 32'h40, MASK_WORD, 0, 32'hCAFE_F00D, 2, 0, 32'h0, "ws0_wr");
    txn(1, 0, BASE + 32'h40, MASK_WORD, 0, 32'h0, 2, 0, 32'hCAFE_F00D, "ws0_rd");
    txn(1, 0, BASE + 32'h42, MASK_HALF, 1, 32'h0, 2, 0, 32'hFFFF_CAFE, "ws0_rd_half");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the CPU data-memory bus (we/addr/mask/signed_ext/wdata -> rdata); it replaces the zero-wait combinational RAM model with a handshaked, multi-cycle, byte-addressed data memory.
- Adds req/ready handshake, configurable wait states, and alignment/range error reporting, so the multi-cycle CPU FSM can be exercised against realistic memory latency.
- Sits between the CPU core and storage at the SoC top, in place of the current data RAM instance.

Parameters:
- DEPTH_BYTES, 2048, storage size in bytes; power of two, at least 4.
- BASE_ADDR, 32'h1001_0000, first byte address decoded; must be DEPTH_BYTES-aligned.
- WAIT_STATES, 2, extra cycles inserted before the access commits; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- mask  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- signed_ext  in  1  reads only: 1 sign-extends, 0 zero-extends halfword/byte.
- wdata  in  32  write data, low-aligned (byte = wdata[7:0], half = wdata[15:0]).
- ready  out  1  one-cycle response pulse.
- rdata  out  32  read data; valid while ready=1.
- err  out  1  error flag; valid while ready=1.

Behaviour:
- Reset:
  - ready=0, rdata=0, err=0, FSM=IDLE, wait counter=0.
  - Storage is not cleared.
  - Reset asserted mid-transaction aborts it; a write not yet committed is never committed.
- FSM: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with req=1, capture we, addr, mask, signed_ext and wdata into internal registers. Later input changes have no effect.
  - Error check at capture:
    - misaligned: word with addr[1:0]!=0, or half with addr[0]!=0;
    - out of range: (addr - BASE_ADDR) >= DEPTH_BYTES, unsigned 32-bit subtract.
  - On error: go to RESP with err=1 and rdata=0; storage is untouched.
  - Otherwise: go to WAIT with counter=WAIT_STATES.
- WAIT:
  - counter!=0: decrement it.
  - counter==0: perform the access on this edge and go to RESP.
- Access:
  - Storage is little-endian; byte offset = addr - BASE_ADDR.
  - Write: store 1, 2 or 4 bytes; rdata=0 in the response.
  - Read: rdata = byte or half at the offset, extended per signed_ext to 32 bits; word reads ignore signed_ext.
- RESP:
  - ready=1, rdata and err hold their values for exactly one cycle, then return to IDLE.
  - On the return, ready, err and rdata go to 0.
  - req is ignored in WAIT and RESP and is not queued.
- Latency, counting the req-sampled cycle as cycle 0:
  - good access: ready=1 in cycle WAIT_STATES+2;
  - error: ready=1 in cycle 1.
- Back-to-back: the earliest next acceptance is the edge after the RESP cycle, so throughput is at most one access per WAIT_STATES+3 cycles.
- Read-after-write to the same address in the next transaction returns the new data.
- Write to the last byte (offset DEPTH_BYTES-1, mask 10) is legal; a word at offset DEPTH_BYTES-4 is legal.
- The offset never wraps: addr below BASE_ADDR underflows to a large value and reports err.

Decomposition:
- Shared package holds:
  - size-code constants MASK_WORD=2'b00, MASK_HALF=2'b01, MASK_BYTE=2'b10;
  - FSM state encodings;
  - default BASE_ADDR.
- One natural sub-module: mem_bus_byte_array. It is a synchronous byte-lane storage array with a 4-bit byte-enable write and a 32-bit aligned-word read.
- The responder holds the FSM, error check, lane steering and sign/zero extension.

Test Plan:
- WAIT_STATES=2, word write addr=32'h1001_0010, wdata=32'hDEAD_BEEF -> ready pulses in cycle 4, err=0. A word read of the same address -> ready in cycle 4, rdata=32'hDEAD_BEEF.
- Byte reads after the above:
  - addr 32'h1001_0013, signed_ext=1 -> rdata=32'hFFFF_FFDE;
  - same addr, signed_ext=0 -> 32'h0000_00DE;
  - half read addr 32'h1001_0010, signed_ext=1 -> 32'hFFFF_BEEF.
- Half write addr 32'h1001_0012, wdata=32'h0000_1234, then word read of 32'h1001_0010 -> 32'h1234_BEEF.
- Errors:
  - word read addr 32'h1001_0002 -> ready in cycle 1, err=1, rdata=0;
  - word write addr 32'h1001_0800 -> err=1, and a read of 32'h1001_07FC is unchanged;
  - addr 32'h0000_0000 -> err=1.
- req held high continuously, plus a req pulse during WAIT -> exactly one response per accepted request, spaced WAIT_STATES+3 cycles. With WAIT_STATES=0, ready comes in cycle 2.
- Reset asserted in the first WAIT cycle of a write of 32'h5555_5555 over stored 32'hDEAD_BEEF -> ready=0 immediately, FSM=IDLE, and a later read returns 32'hDEAD_BEEF.
